// File: rtl/ethernet_rx_frame_buffer_pkg.sv
// Shared types and constants for the Ethernet RX frame buffer:
// the MAC RX bus, the minimum legal frame size, the performance
// counter bundle and the write-side FSM states.
// The perf_runts field exists only when ETH_RX_BUFFER_RUNT_FILTER_EN is defined.
package ethernet_rx_frame_buffer_pkg;

  // MAC RX bus; data arrives before the FCS verdict (commit/drop).
  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
    logic        commit;
    logic        drop;
  } EthernetRxBus;

  // Smallest frame (without FCS) that the runt filter lets through.
  localparam int unsigned ETH_MIN_FRAME_BYTES = 60;

  // Performance counters exported by the frame buffer.
  typedef struct packed {
    logic [31:0] frames;
    logic [31:0] crc_drops;
    logic [31:0] overflows;
    logic [31:0] truncated;
`ifdef ETH_RX_BUFFER_RUNT_FILTER_EN
    logic [31:0] runts;
`endif
  } RxFrameBufferCounters;

  // Write-side (speculative ingest) FSM states.
  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_RECEIVE = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_e;

endpackage

// File: rtl/SingleClockFifo.sv
// Single-clock FIFO with registered full/empty flags and a
// first-word-fall-through read port (pop_data shows the head entry).
// Pushes while full and pops while empty are ignored.
module SingleClockFifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic [AW-1:0]    rd_idx_q, rd_idx_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push_s, do_pop_s;

  assign do_push_s = push && !full_q;
  assign do_pop_s  = pop && !empty_q;
  assign pop_data  = mem_q[rd_idx_q];
  assign full      = full_q;
  assign empty     = empty_q;

  // Next-state for indices, occupancy and the registered flags
  always_comb begin
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_idx_d = wr_idx_q + AW'(1);
    end else begin
      wr_idx_d = wr_idx_q;
    end
    if (do_pop_s) begin
      rd_idx_d = rd_idx_q + AW'(1);
    end else begin
      rd_idx_d = rd_idx_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Index, occupancy and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage write; contents need no reset because the flags guard reads
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_idx_q] <= push_data;
    end
  end

endmodule

// File: rtl/ethernet_rx_frame_buffer.sv
// Ethernet RX frame buffer. Frames from the MAC are written speculatively
// into a word buffer and only published (length pushed, wr_ptr advanced)
// on commit; drop, overflow and truncation roll the write pointer back.
// The reader pops whole, CRC-clean frames with the length known up front.
// Optional: ETH_RX_BUFFER_RUNT_FILTER_EN rejects frames under 60 bytes and
// adds the perf_runts output.
module ethernet_rx_frame_buffer
  import ethernet_rx_frame_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned MAX_FRAMES  = 32,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  EthernetRxBus         rx_bus,
  output logic                 frame_valid,
  output logic [LEN_WIDTH-1:0] frame_len,
  input  logic                 rd_en,
  output logic                 rd_valid,
  output logic [31:0]          rd_data,
  output logic [2:0]           rd_bytes_valid,
  output logic                 rd_last,
  output logic [31:0]          perf_frames,
  output logic [31:0]          perf_crc_drops,
  output logic [31:0]          perf_overflows,
  output logic [31:0]          perf_truncated
`ifdef ETH_RX_BUFFER_RUNT_FILTER_EN
  ,
  output logic [31:0]          perf_runts
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned WL = LEN_WIDTH - 1;

  // Data buffer: {bytes_valid, data}
  logic [34:0] mem_q [DEPTH_WORDS];

  // Write side
  wr_state_e            state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        wr_ptr_tmp_q, wr_ptr_tmp_d;
  logic [LEN_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [LEN_WIDTH:0]   byte_sum_s;
  RxFrameBufferCounters cnt_q, cnt_d;
  logic                 mem_we_s;
  logic                 buf_full_s;

  // Length FIFO
  logic                 len_push_s, len_pop_s;
  logic                 len_full_s, len_empty_s;
  logic [LEN_WIDTH-1:0] len_head_s;

  // Read side
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [WL-1:0]        words_left_q, words_left_d;
  logic [WL-1:0]        words_first_s, words_cur_s;
  logic                 rd_accept_s, rd_is_last_s;
  logic                 rd_valid_q, rd_last_q;
  logic [34:0]          rd_entry_q;

  // Conservative full check against the registered read pointer.
  assign buf_full_s = ((wr_ptr_tmp_q - rd_ptr_q) == PW'(DEPTH_WORDS));
  assign byte_sum_s = {1'b0, byte_cnt_q} + (LEN_WIDTH+1)'(rx_bus.bytes_valid);

  SingleClockFifo #(
    .WIDTH (LEN_WIDTH),
    .DEPTH (MAX_FRAMES)
  ) u_len_fifo (
    .clk       (clk),
    .rst       (!rst_n),
    .push      (len_push_s),
    .push_data (byte_cnt_q),
    .pop       (len_pop_s),
    .pop_data  (len_head_s),
    .full      (len_full_s),
    .empty     (len_empty_s)
  );

  // Write FSM next state: speculative ingest, commit or roll back
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_ptr_tmp_d = wr_ptr_tmp_q;
    byte_cnt_d   = byte_cnt_q;
    cnt_d        = cnt_q;
    mem_we_s     = 1'b0;
    len_push_s   = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (rx_bus.start) begin
          wr_ptr_tmp_d = wr_ptr_q;
          byte_cnt_d   = '0;
          state_d      = WR_RECEIVE;
        end else begin
          state_d = WR_IDLE;
        end
      end
      WR_RECEIVE: begin
        if (rx_bus.start) begin
          // New frame before a verdict: abandon the partial one.
          wr_ptr_tmp_d    = wr_ptr_q;
          byte_cnt_d      = '0;
          cnt_d.truncated = cnt_q.truncated + 32'd1;
          state_d         = WR_RECEIVE;
        end else if (rx_bus.drop) begin
          wr_ptr_tmp_d    = wr_ptr_q;
          cnt_d.crc_drops = cnt_q.crc_drops + 32'd1;
          state_d         = WR_IDLE;
        end else if (rx_bus.commit) begin
          if (len_full_s) begin
            wr_ptr_tmp_d    = wr_ptr_q;
            cnt_d.overflows = cnt_q.overflows + 32'd1;
          end else if (byte_cnt_q == '0) begin
            wr_ptr_tmp_d = wr_ptr_q;
`ifdef ETH_RX_BUFFER_RUNT_FILTER_EN
          end else if (byte_cnt_q < LEN_WIDTH'(ETH_MIN_FRAME_BYTES)) begin
            wr_ptr_tmp_d = wr_ptr_q;
            cnt_d.runts  = cnt_q.runts + 32'd1;
`endif
          end else begin
            len_push_s   = 1'b1;
            wr_ptr_d     = wr_ptr_tmp_q;
            cnt_d.frames = cnt_q.frames + 32'd1;
          end
          state_d = WR_IDLE;
        end else if (rx_bus.data_valid) begin
          if (buf_full_s) begin
            wr_ptr_tmp_d    = wr_ptr_q;
            cnt_d.overflows = cnt_q.overflows + 32'd1;
            state_d         = WR_DISCARD;
          end else begin
            mem_we_s     = 1'b1;
            wr_ptr_tmp_d = wr_ptr_tmp_q + PW'(1);
            if (byte_sum_s[LEN_WIDTH]) begin
              byte_cnt_d = '1;
            end else begin
              byte_cnt_d = byte_sum_s[LEN_WIDTH-1:0];
            end
          end
        end else begin
          state_d = WR_RECEIVE;
        end
      end
      WR_DISCARD: begin
        if (rx_bus.start) begin
          wr_ptr_tmp_d = wr_ptr_q;
          byte_cnt_d   = '0;
          state_d      = WR_RECEIVE;
        end else if (rx_bus.commit || rx_bus.drop) begin
          state_d = WR_IDLE;
        end else begin
          state_d = WR_DISCARD;
        end
      end
      default: begin
        wr_ptr_tmp_d = wr_ptr_q;
        state_d      = WR_IDLE;
      end
    endcase
  end

  // Write FSM, pointer and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= WR_IDLE;
      wr_ptr_q     <= '0;
      wr_ptr_tmp_q <= '0;
      byte_cnt_q   <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_ptr_tmp_q <= wr_ptr_tmp_d;
      byte_cnt_q   <= byte_cnt_d;
      cnt_q        <= cnt_d;
    end
  end

  // Data buffer write port
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_tmp_q[AW-1:0]] <= {rx_bus.bytes_valid, rx_bus.data};
    end
  end

  assign rd_accept_s   = rd_en && !len_empty_s;
  assign words_first_s = WL'(({1'b0, len_head_s} + (LEN_WIDTH+1)'(3)) >> 2);

  // Read-side next state: word countdown per frame, head-length pop on last word
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    words_left_d = words_left_q;
    words_cur_s  = words_left_q;
    rd_is_last_s = 1'b0;
    len_pop_s    = 1'b0;
    if (words_left_q == '0) begin
      words_cur_s = words_first_s;
    end else begin
      words_cur_s = words_left_q;
    end
    rd_is_last_s = (words_cur_s == WL'(1));
    if (rd_accept_s) begin
      rd_ptr_d     = rd_ptr_q + PW'(1);
      words_left_d = words_cur_s - WL'(1);
      len_pop_s    = rd_is_last_s;
    end else begin
      rd_ptr_d     = rd_ptr_q;
      words_left_d = words_left_q;
    end
  end

  // Read pointer, countdown and registered read port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      words_left_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_entry_q   <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      words_left_q <= words_left_d;
      rd_valid_q   <= rd_accept_s;
      rd_last_q    <= rd_accept_s && rd_is_last_s;
      if (rd_accept_s) begin
        rd_entry_q <= mem_q[rd_ptr_q[AW-1:0]];
      end else begin
        rd_entry_q <= rd_entry_q;
      end
    end
  end

  assign frame_valid    = !len_empty_s;
  assign frame_len      = frame_valid ? len_head_s : '0;
  assign rd_valid       = rd_valid_q;
  assign rd_last        = rd_last_q;
  assign rd_data        = rd_entry_q[31:0];
  assign rd_bytes_valid = rd_entry_q[34:32];
  assign perf_frames    = cnt_q.frames;
  assign perf_crc_drops = cnt_q.crc_drops;
  assign perf_overflows = cnt_q.overflows;
  assign perf_truncated = cnt_q.truncated;
`ifdef ETH_RX_BUFFER_RUNT_FILTER_EN
  assign perf_runts     = cnt_q.runts;
`endif

endmodule

// File: tb/tb_ethernet_rx_frame_buffer.sv
// Self-checking bench for ethernet_rx_frame_buffer. Expected read beats are
// queued as frames are driven and compared as the DUT emits them.
module tb_ethernet_rx_frame_buffer;
  import ethernet_rx_frame_buffer_pkg::*;

  localparam int unsigned DEPTH_WORDS = 512;
  localparam int unsigned MAX_FRAMES  = 4;
  localparam int unsigned LEN_WIDTH   = 16;
  localparam int OP_COMMIT = 0;
  localparam int OP_DROP   = 1;
  localparam int OP_NONE   = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  bv;
    logic        last;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  EthernetRxBus         rx_bus;
  logic                 frame_valid;
  logic [LEN_WIDTH-1:0] frame_len;
  logic                 rd_en;
  logic                 rd_valid;
  logic [31:0]          rd_data;
  logic [2:0]           rd_bytes_valid;
  logic                 rd_last;
  logic [31:0]          perf_frames, perf_crc_drops, perf_overflows, perf_truncated;
`ifdef ETH_RX_BUFFER_RUNT_FILTER_EN
  logic [31:0]          perf_runts;
`endif

  beat_t exp_q[$];
  beat_t mon_e;
  int checks_total;
  int checks_passed;
  int exp_frames, exp_drops, exp_ovf, exp_trunc, exp_runts;

  ethernet_rx_frame_buffer #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .MAX_FRAMES  (MAX_FRAMES),
    .LEN_WIDTH   (LEN_WIDTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_bus         (rx_bus),
    .frame_valid    (frame_valid),
    .frame_len      (frame_len),
    .rd_en          (rd_en),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_bytes_valid (rd_bytes_valid),
    .rd_last        (rd_last),
    .perf_frames    (perf_frames),
    .perf_crc_drops (perf_crc_drops),
    .perf_overflows (perf_overflows),
    .perf_truncated (perf_truncated)
`ifdef ETH_RX_BUFFER_RUNT_FILTER_EN
    ,
    .perf_runts     (perf_runts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every output beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("beat_expected", 64'(rd_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat", 64'({rd_data, rd_bytes_valid, rd_last}), 64'(mon_e));
      end
    end
  end

  task automatic check_counters(input string tag);
    check({tag, "_frames"}, 64'(perf_frames), 64'(exp_frames));
    check({tag, "_drops"}, 64'(perf_crc_drops), 64'(exp_drops));
    check({tag, "_ovf"}, 64'(perf_overflows), 64'(exp_ovf));
    check({tag, "_trunc"}, 64'(perf_truncated), 64'(exp_trunc));
`ifdef ETH_RX_BUFFER_RUNT_FILTER_EN
    check({tag, "_runts"}, 64'(perf_runts), 64'(exp_runts));
`endif
  endtask

  // Drive start, nbytes of data, then the verdict; queue beats if published.
  task automatic send_frame(input int nbytes, input int seed, input int op, input bit publish);
    int nwords;
    int rem;
    beat_t b;
    nwords = (nbytes + 3) / 4;
    @(negedge clk);
    rx_bus = '0;
    rx_bus.start = 1'b1;
    for (int w = 0; w < nwords; w++) begin
      @(negedge clk);
      rx_bus = '0;
      rx_bus.data_valid = 1'b1;
      rem = nbytes - 4 * w;
      rx_bus.bytes_valid = (rem >= 4) ? 3'd4 : 3'(rem);
      for (int k = 0; k < 4; k++) begin
        if (k < rem) rx_bus.data[31 - 8 * k -: 8] = 8'(seed * 17 + (4 * w + k) * 3 + 1);
      end
      if (publish) begin
        b.data = rx_bus.data;
        b.bv   = rx_bus.bytes_valid;
        b.last = (w == nwords - 1);
        exp_q.push_back(b);
      end
    end
    @(negedge clk);
    rx_bus = '0;
    if (op == OP_COMMIT) rx_bus.commit = 1'b1;
    else if (op == OP_DROP) rx_bus.drop = 1'b1;
    @(negedge clk);
    rx_bus = '0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    rx_bus = '0;
    rd_en  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check_counters("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // 64-byte frame, visible right after commit, read with rd_en held
    send_frame(64, 1, OP_COMMIT, 1'b1);
    exp_frames++;
    check("f64_valid", 64'(frame_valid), 64'd1);
    check("f64_len", 64'(frame_len), 64'd64);
    rd_en = 1'b1;
    wait_drain("f64");
    check("f64_valid_after", 64'(frame_valid), 64'd0);

    // 61-byte frame: last beat carries one byte
    rd_en = 1'b0;
    send_frame(61, 2, OP_COMMIT, 1'b1);
    exp_frames++;
    check("f61_len", 64'(frame_len), 64'd61);
    rd_en = 1'b1;
    wait_drain("f61");

    // A committed, B dropped, C committed; reader continuously enabled
    send_frame(48, 3, OP_COMMIT, 1'b1);
    send_frame(100, 4, OP_DROP, 1'b0);
    send_frame(72, 5, OP_COMMIT, 1'b1);
    exp_frames += 2;
    exp_drops++;
    wait_drain("abc");
    check_counters("abc");

    // Oversized frame with stalled reader overflows; next frame is fine
    rd_en = 1'b0;
    send_frame(3000, 6, OP_COMMIT, 1'b0);
    exp_ovf++;
    check("ovf_valid", 64'(frame_valid), 64'd0);
    send_frame(64, 7, OP_COMMIT, 1'b1);
    exp_frames++;
    check("post_ovf_valid", 64'(frame_valid), 64'd1);
    check("post_ovf_len", 64'(frame_len), 64'd64);
    rd_en = 1'b1;
    wait_drain("ovf");
    check_counters("ovf");

    // Length FIFO full: the extra commit is lost as an overflow
    rd_en = 1'b0;
    for (int i = 0; i < MAX_FRAMES; i++) begin
      send_frame(8, 20 + i, OP_COMMIT, 1'b1);
      exp_frames++;
    end
    send_frame(8, 30, OP_COMMIT, 1'b0);
    exp_ovf++;
    check("lenfull_head", 64'(frame_len), 64'd8);
    rd_en = 1'b1;
    wait_drain("lenfull");
    check_counters("lenfull");

    // Truncation: 10 words, then a new start, then a full 64-byte frame
    send_frame(40, 8, OP_NONE, 1'b0);
    send_frame(64, 9, OP_COMMIT, 1'b1);
    exp_frames++;
    exp_trunc++;
    wait_drain("trunc");
    check_counters("trunc");

    // Empty commit publishes nothing and counts nothing
    rd_en = 1'b0;
    send_frame(0, 10, OP_COMMIT, 1'b0);
    check("empty_valid", 64'(frame_valid), 64'd0);
    check_counters("empty");

    // Reset mid-read and mid-frame
    send_frame(64, 11, OP_COMMIT, 1'b1);
    @(negedge clk);
    rx_bus = '0;
    rx_bus.start = 1'b1;
    @(negedge clk);
    rx_bus = '0;
    rx_bus.data_valid = 1'b1;
    rx_bus.bytes_valid = 3'd4;
    rx_bus.data = 32'hDEADBEEF;
    rd_en = 1'b1;
    repeat (4) @(negedge clk);
    rst_n  = 1'b0;
    rd_en  = 1'b0;
    rx_bus = '0;
    @(negedge clk);
    check("rstmid_frame_valid", 64'(frame_valid), 64'd0);
    check("rstmid_frame_len", 64'(frame_len), 64'd0);
    check("rstmid_rd", 64'({rd_valid, rd_data, rd_bytes_valid, rd_last}), 64'd0);
    exp_q.delete();
    exp_frames = 0;
    exp_drops  = 0;
    exp_ovf    = 0;
    exp_trunc  = 0;
    exp_runts  = 0;
    check_counters("rstmid");
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(64, 12, OP_COMMIT, 1'b1);
    exp_frames++;
    check("rstpost_len", 64'(frame_len), 64'd64);
    rd_en = 1'b1;
    wait_drain("rstpost");
    check_counters("rstpost");

`ifdef ETH_RX_BUFFER_RUNT_FILTER_EN
    // Runt rejected; exactly-minimum frame accepted
    rd_en = 1'b0;
    send_frame(40, 13, OP_COMMIT, 1'b0);
    exp_runts++;
    check("runt_valid", 64'(frame_valid), 64'd0);
    rd_en = 1'b1;
    send_frame(60, 14, OP_COMMIT, 1'b1);
    exp_frames++;
    wait_drain("min60");
`else
    // Without the filter short frames, even one byte, are published
    send_frame(40, 13, OP_COMMIT, 1'b1);
    send_frame(1, 14, OP_COMMIT, 1'b1);
    exp_frames += 2;
    wait_drain("short");
`endif
    check_counters("final");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
